// File: rtl/unpack_pkg.sv
// Shared types and helpers for the queue unpacker and a future packer stage.
package unpack_pkg;

    typedef enum logic {EMPTY, SEND} unpack_state_t;

    // Number of narrow beats per wide queue word.
    function automatic int unpack_ratio(input int inWidth, input int outWidth);
        return inWidth / outWidth;
    endfunction

endpackage

// File: rtl/unpack_beat_counter.sv
// Beat index within the held word: 0..Ratio-1.
// Wraps explicitly at Ratio-1, so Ratio does not have to be a power of two.
module unpack_beat_counter #(
    parameter int Ratio = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    output logic [$clog2(Ratio)-1:0]   cnt,
    output logic                       tc
);
    localparam int CntW = $clog2(Ratio);
    localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

    // A clear takes priority over counting; at terminal count the counter wraps to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

    assign tc = (cnt == LastCnt);

endmodule

// File: rtl/queue_unpacker.sv
// Pops one InWidth-bit word from the queue and emits it as InWidth/OutWidth
// narrow beats, least-significant slice first. A new word is popped in the same
// cycle as the last beat is accepted, so back-to-back words have no bubble.
// Optional macro UNPACK_LAST_EN adds the dOutLAST output (final beat of a word).
module queue_unpacker
    import unpack_pkg::*;
#(
    parameter int InWidth  = 32,
    parameter int OutWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                qOutACK,
    output logic                qOutREQ,
    input  logic [InWidth-1:0]  qDIN,
    output logic                dOutACK,
    input  logic                dOutREQ,
    output logic [OutWidth-1:0] dOUT,
`ifdef UNPACK_LAST_EN
    output logic                dOutLAST,
`endif
    output logic                Busy
);
    localparam int Ratio = unpack_ratio(InWidth, OutWidth);
    localparam int CntW  = $clog2(Ratio);

    if ((InWidth % OutWidth) != 0 || Ratio < 2) begin : gBadCfg
        $error("queue_unpacker: InWidth must be a multiple of OutWidth with ratio >= 2");
    end

    unpack_state_t       state, nextState;
    logic [InWidth-1:0]  hold;
    logic [CntW-1:0]     beatCnt;
    logic                lastBeat;
    logic                pop;
    logic                beat;

    assign beat = dOutACK && dOutREQ;

    unpack_beat_counter #(.Ratio(Ratio)) uBeatCnt (
        .clk (clk),
        .rst (rst),
        .en  (beat),
        .clr (pop || (beat && lastBeat)),
        .cnt (beatCnt),
        .tc  (lastBeat)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= nextState;
    end

    // Holding register captures the queue head on every pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold <= '0;
        else if (pop)
            hold <= qDIN;
    end

    // Next state and handshake outputs; the pop request on the last beat is
    // combinational from dOutREQ to close the word boundary without a gap.
    always_comb begin
        nextState = state;
        qOutREQ   = 1'b0;
        dOutACK   = 1'b0;
        Busy      = 1'b0;
        pop       = 1'b0;
        case (state)
            EMPTY: begin
                qOutREQ = !rst;
                pop     = qOutACK && qOutREQ;
                if (pop)
                    nextState = SEND;
            end
            SEND: begin
                dOutACK = 1'b1;
                Busy    = 1'b1;
                if (dOutREQ && lastBeat) begin
                    qOutREQ   = !rst;
                    pop       = qOutACK && qOutREQ;
                    nextState = pop ? SEND : EMPTY;
                end
            end
            default: nextState = EMPTY;
        endcase
    end

    // Slice mux: select the beat at the current index.
    always_comb begin
        dOUT = '0;
        for (int i = 0; i < Ratio; i++)
            if (beatCnt == CntW'(i))
                dOUT = hold[i*OutWidth +: OutWidth];
    end

`ifdef UNPACK_LAST_EN
    assign dOutLAST = dOutACK && lastBeat;
`endif

endmodule

// File: tb/tb_queue_unpacker.sv
// Directed bench for queue_unpacker: a 32->8 instance fed from a small queue
// model and a 24->8 instance for the non-power-of-two beat count.
module tb_queue_unpacker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        qOutACK = 1'b0, qOutREQ;
    logic [31:0] qDIN = '0;
    logic        dOutACK, dOutREQ = 1'b0, Busy;
    logic [7:0]  dOUT;

    logic        bAck = 1'b0, bQReq;
    logic [23:0] bDin = '0;
    logic        bVld, bReq = 1'b0, bBusy;
    logic [7:0]  bOut;
`ifdef UNPACK_LAST_EN
    logic        aLast, bLast;
`endif

    int passed = 0;
    int total  = 0;

    logic [31:0] q[$];
    logic [7:0]  expBeats[$];

    always #5 clk = ~clk;

    queue_unpacker #(.InWidth(32), .OutWidth(8)) dutA (
        .clk(clk), .rst(rst), .qOutACK(qOutACK), .qOutREQ(qOutREQ), .qDIN(qDIN),
        .dOutACK(dOutACK), .dOutREQ(dOutREQ), .dOUT(dOUT),
`ifdef UNPACK_LAST_EN
        .dOutLAST(aLast),
`endif
        .Busy(Busy)
    );

    queue_unpacker #(.InWidth(24), .OutWidth(8)) dutB (
        .clk(clk), .rst(rst), .qOutACK(bAck), .qOutREQ(bQReq), .qDIN(bDin),
        .dOutACK(bVld), .dOutREQ(bReq), .dOUT(bOut),
`ifdef UNPACK_LAST_EN
        .dOutLAST(bLast),
`endif
        .Busy(bBusy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic refresh();
        qOutACK = (q.size() != 0);
        qDIN    = (q.size() != 0) ? q[0] : 32'h0;
    endtask

    // Settle, note whether the queue model is popped at this edge, then advance.
    task automatic tick();
        bit p;
        #1;
        p = qOutACK && qOutREQ;
        @(posedge clk);
        #1;
        if (p) void'(q.pop_front());
        refresh();
    endtask

    task automatic checkBeat(input string tag, input logic [7:0] exp);
        #1;
        check({tag, " ack"}, 32'(dOutACK), 32'h1);
        check({tag, " dout"}, 32'(dOUT), 32'(exp));
    endtask

    initial begin
        logic [7:0] t3[8];
        int cyc;
        t3 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

        // Reset state
        #1;
        check("rst qOutREQ", 32'(qOutREQ), 32'h0);
        check("rst dOutACK", 32'(dOutACK), 32'h0);
        check("rst Busy", 32'(Busy), 32'h0);
        check("rst dOUT", 32'(dOUT), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("idle qOutREQ", 32'(qOutREQ), 32'h1);
        check("idle dOutACK", 32'(dOutACK), 32'h0);

        // T2 single word
        dOutREQ = 1'b1;
        q.push_back(32'hA1B2C3D4);
        refresh();
        tick();
        checkBeat("t2 b0", 8'hD4);
        check("t2 busy", 32'(Busy), 32'h1);
        check("t2 b0 qreq", 32'(qOutREQ), 32'h0);
        tick(); checkBeat("t2 b1", 8'hC3);
        tick(); checkBeat("t2 b2", 8'hB2);
        tick(); checkBeat("t2 b3", 8'hA1);
        check("t2 last qreq", 32'(qOutREQ), 32'h1);
`ifdef UNPACK_LAST_EN
        check("t6 last on A1", 32'(aLast), 32'h1);
`endif
        tick();
        check("t2 empty ack", 32'(dOutACK), 32'h0);
        check("t2 empty busy", 32'(Busy), 32'h0);

        // T3 back-to-back words, no bubble
        q.push_back(32'h11223344);
        q.push_back(32'h55667788);
        refresh();
        tick();
        for (int i = 0; i < 8; i++) begin
            checkBeat($sformatf("t3 b%0d", i), t3[i]);
            if (i == 3) begin
                check("t3 pop qreq", 32'(qOutREQ), 32'h1);
                check("t3 pop qack", 32'(qOutACK), 32'h1);
            end
`ifdef UNPACK_LAST_EN
            check($sformatf("t3 last%0d", i), 32'(aLast), 32'((i == 3) || (i == 7)));
`endif
            tick();
        end
        check("t3 empty ack", 32'(dOutACK), 32'h0);

        // T4 stall on beat 1
        q.push_back(32'hA1B2C3D4);
        refresh();
        tick();
        checkBeat("t4 b0", 8'hD4);
        tick();
        dOutREQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkBeat($sformatf("t4 stall%0d", i), 8'hC3);
            check($sformatf("t4 stall qreq%0d", i), 32'(qOutREQ), 32'h0);
            tick();
        end
        dOutREQ = 1'b1;
        checkBeat("t4 resume", 8'hC3);
        tick(); checkBeat("t4 b2", 8'hB2);
        tick(); checkBeat("t4 b3", 8'hA1);
        tick();
        check("t4 empty ack", 32'(dOutACK), 32'h0);

        // T1 reset mid-word
        q.push_back(32'hA1B2C3D4);
        refresh();
        tick();
        tick();
        checkBeat("t1 pre", 8'hC3);
        rst = 1'b1;
        #1;
        check("t1 ack", 32'(dOutACK), 32'h0);
        check("t1 busy", 32'(Busy), 32'h0);
        check("t1 qreq", 32'(qOutREQ), 32'h0);
        check("t1 dout", 32'(dOUT), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("t1 rel qreq", 32'(qOutREQ), 32'h1);
        check("t1 rel ack", 32'(dOutACK), 32'h0);

        // T5 non-power-of-two ratio on the 24-bit instance
        bReq = 1'b1;
        bAck = 1'b1;
        bDin = 24'hABCDEF;
        tick();
        bAck = 1'b0;
        #1;
        check("t5 b0", 32'(bOut), 32'hEF);
        check("t5 b0 ack", 32'(bVld), 32'h1);
        tick(); check("t5 b1", 32'(bOut), 32'hCD);
        tick(); check("t5 b2", 32'(bOut), 32'hAB);
        check("t5 last qreq", 32'(bQReq), 32'h1);
`ifdef UNPACK_LAST_EN
        check("t5 last", 32'(bLast), 32'h1);
`endif
        bAck = 1'b1;
        bDin = 24'h123456;
        tick();
        bAck = 1'b0;
        #1;
        check("t5 wrap b0", 32'(bOut), 32'h56);
        check("t5 wrap ack", 32'(bVld), 32'h1);
        tick(); check("t5 wrap b1", 32'(bOut), 32'h34);
        tick(); check("t5 wrap b2", 32'(bOut), 32'h12);
        tick();
        check("t5 empty", 32'(bVld), 32'h0);

        // Random consumer readiness against a queue model scoreboard
        for (int w = 0; w < 6; w++) begin
            logic [31:0] word;
            word = $urandom;
            q.push_back(word);
            for (int k = 0; k < 4; k++) expBeats.push_back(word[k*8 +: 8]);
        end
        refresh();
        cyc = 0;
        while ((expBeats.size() != 0) && (cyc < 400)) begin
            dOutREQ = 1'($urandom_range(0, 1));
            #1;
            if (dOutACK && dOutREQ) begin
                check("sb dout", 32'(dOUT), 32'(expBeats[0]));
`ifdef UNPACK_LAST_EN
                check("sb last", 32'(aLast), 32'((expBeats.size() % 4) == 1));
`endif
                void'(expBeats.pop_front());
            end
            tick();
            cyc++;
        end
        check("sb drained", 32'(expBeats.size()), 32'h0);
        dOutREQ = 1'b1;
        tick();
        check("sb final empty", 32'(dOutACK), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
